cart_mem_fetch: RTL and testbench

CART_MEM_FETCH -- requirements
Module: cart_mem_fetch

---
 rtl/cart_mem_pkg.sv | 17 +
 rtl/cart_fetch_cache1.sv | 39 +++
 rtl/cart_mem_fetch.sv | 162 ++++++++++++++++
 tb/tb_cart_mem_fetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory fetch path.
package cart_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROM_REQ,
    SRAM_RD,
    SRAM_WR,
    HOLD,
    DRAIN
  } state_t;

  typedef logic [24:0] addr_t;

  localparam logic [7:0] RD_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/cart_fetch_cache1.sv
// One-entry ROM fetch cache: tag + data of the last byte returned by SDRAM.
// Only instantiated when CART_MEM_FETCH_CACHE_EN is defined.
module cart_fetch_cache1
  import cart_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       fill,
  input  addr_t      fill_addr,
  input  logic [7:0] fill_data,
  input  addr_t      lookup_addr,
  output logic       hit,
  output logic [7:0] hit_data
);

  logic       valid;
  addr_t      tag;
  logic [7:0] data;

  // Entry update: flush dominates a same-cycle fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= RD_IDLE_DATA;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end
  end

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

endmodule

// File: rtl/cart_mem_fetch.sv
// Cartridge memory fetch: arbitrates mapper ROM/SRAM strobes onto an SDRAM
// read port and a block-RAM port, and stalls the CPU via wait_n.
// Optional feature: define CART_MEM_FETCH_CACHE_EN for a one-entry ROM cache.
module cart_mem_fetch
  import cart_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned SRAM_AW     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [24:0]        mem_addr,
  input  logic               mem_oe,
  input  logic [SRAM_AW-1:0] sram_addr,
  input  logic               sram_oe,
  input  logic               sram_we,
  input  logic [7:0]         d_from_cpu,
  input  logic               flush,
  output logic [7:0]         d_to_cpu,
  output logic               wait_n,
  output logic               sdram_req,
  output logic [24:0]        sdram_addr,
  input  logic               sdram_ack,
  input  logic [7:0]         sdram_rdata,
  output logic [SRAM_AW-1:0] bram_addr,
  output logic               bram_we,
  output logic [7:0]         bram_wdata,
  input  logic [7:0]         bram_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  state_t             state, state_nxt;
  logic               any, any_q, start, timeout;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [7:0]         wdata_q;
  logic               hit;
  logic [7:0]         hit_data;

  assign any     = mem_oe | sram_oe | sram_we;
  assign start   = any & ~any_q;
  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

`ifdef CART_MEM_FETCH_CACHE_EN
  logic fill;

  // Only an ack taken in ROM_REQ fills; drained or timed-out accesses do not.
  assign fill = sdram_ack && (state == ROM_REQ);

  cart_fetch_cache1 u_cache (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fill        (fill),
    .fill_addr   (sdram_addr),
    .fill_data   (sdram_rdata),
    .lookup_addr (mem_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_data     = RD_IDLE_DATA;
`endif

  // Strobe history tracks the pins even during reset, so a strobe still high
  // when reset releases cannot restart an access.
  always_ff @(posedge clk) begin
    any_q <= any;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and control outputs.
  always_comb begin
    state_nxt = state;
    wait_n    = 1'b1;
    sdram_req = 1'b0;
    bram_we   = 1'b0;
    bram_addr = sram_addr_q;
    unique case (state)
      IDLE: begin
        bram_addr = sram_addr;
        if (start) begin
          wait_n = 1'b0;
          if (sram_we)      state_nxt = SRAM_WR;
          else if (sram_oe) state_nxt = SRAM_RD;
          else if (hit)     state_nxt = HOLD;
          else              state_nxt = ROM_REQ;
        end
      end
      ROM_REQ: begin
        wait_n    = 1'b0;
        sdram_req = 1'b1;
        if (sdram_ack || timeout) state_nxt = HOLD;
        else if (!any)            state_nxt = DRAIN;
      end
      SRAM_RD: begin
        wait_n    = 1'b0;
        state_nxt = HOLD;
      end
      SRAM_WR: begin
        wait_n    = 1'b0;
        bram_we   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!any) state_nxt = IDLE;
      end
      DRAIN: begin
        wait_n    = 1'b0;
        sdram_req = 1'b1;
        if (sdram_ack || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address/data capture at start, read data return, timeout count.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_to_cpu    <= RD_IDLE_DATA;
      sdram_addr  <= '0;
      sram_addr_q <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sram_addr_q <= sram_addr;
            wdata_q     <= d_from_cpu;
            cnt         <= '0;
            if (!sram_we && !sram_oe) begin
              if (hit) d_to_cpu   <= hit_data;
              else     sdram_addr <= mem_addr;
            end
          end
        end
        ROM_REQ: begin
          cnt <= cnt + 1'b1;
          if (sdram_ack)    d_to_cpu <= sdram_rdata;
          else if (timeout) d_to_cpu <= RD_IDLE_DATA;
        end
        DRAIN:   cnt      <= cnt + 1'b1;
        SRAM_RD: d_to_cpu <= bram_rdata;
        default: ;
      endcase
    end
  end

  assign bram_wdata = wdata_q;

endmodule

// File: tb/tb_cart_mem_fetch.sv
// Randomized self-checking bench for cart_mem_fetch against a transaction-level
// model (SRAM byte array, one-entry cache record, timeout rule).
module tb_cart_mem_fetch;

  localparam int unsigned T     = 255;
  localparam int unsigned SAW   = 15;
  localparam int unsigned DEPTH = 1 << SAW;
`ifdef CART_MEM_FETCH_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [24:0]    mem_addr;
  logic           mem_oe;
  logic [SAW-1:0] sram_addr;
  logic           sram_oe, sram_we;
  logic [7:0]     d_from_cpu;
  logic           flush;
  logic [7:0]     d_to_cpu;
  logic           wait_n;
  logic           sdram_req;
  logic [24:0]    sdram_addr;
  logic           sdram_ack;
  logic [7:0]     sdram_rdata;
  logic [SAW-1:0] bram_addr;
  logic           bram_we;
  logic [7:0]     bram_wdata;
  logic [7:0]     bram_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  bram_mem [DEPTH];
  logic [7:0]  ref_sram [DEPTH];
  logic        c_valid;
  logic [24:0] c_tag;
  logic [7:0]  c_data;
  logic [24:0] pool [4];

  cart_mem_fetch #(.TIMEOUT_CYC(T), .SRAM_AW(SAW)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_oe(mem_oe),
    .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_we(sram_we),
    .d_from_cpu(d_from_cpu), .flush(flush), .d_to_cpu(d_to_cpu),
    .wait_n(wait_n), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // Block RAM with one cycle read latency.
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr] <= bram_wdata;
    bram_rdata <= bram_mem[bram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    c_valid = 1'b0;
  endtask

  // ROM access; lat = ROM_REQ cycle carrying the ack (0 = never), abort_at =
  // ROM_REQ cycle in which mem_oe is dropped (0 = never, must be < lat).
  task automatic rom_access(input logic [24:0] a, input int unsigned lat,
                            input logic [7:0] d, input int unsigned abort_at);
    logic        hit_exp, acked, aborted, addr_ok;
    logic [7:0]  d_before, exp_d;
    int unsigned n, k, nw, exp_k;
    hit_exp  = CACHE_EN && c_valid && (c_tag == a);
    acked    = !hit_exp && (lat >= 1) && (lat <= T);
    exp_k    = hit_exp ? 0 : (acked ? lat : T);
    d_before = d_to_cpu;
    mem_addr = a;
    mem_oe   = 1'b1;
    #1;
    check("rom_start_wait", wait_n, 0);
    n = 0; k = 0; nw = 1; aborted = 1'b0; addr_ok = 1'b1;
    forever begin
      tick();
      sdram_ack = 1'b0;
      if (!sdram_req && (aborted || wait_n)) break;
      if (n >= 600) break;
      n++;
      if (!wait_n) nw++;
      if (sdram_req) begin
        k++;
        if (sdram_addr !== a) addr_ok = 1'b0;
        sdram_rdata = 8'($urandom);
        if (k == lat) begin
          sdram_ack   = 1'b1;
          sdram_rdata = d;
        end
        if (abort_at != 0 && k == abort_at) begin
          mem_oe  = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    check("rom_req_cycles", k, exp_k);
    check("rom_wait_cycles", nw, 1 + exp_k);
    if (k > 0) check("rom_sdram_addr", addr_ok, 1);
    check("rom_end_req", sdram_req, 0);
    check("rom_end_wait", wait_n, 1);
    if (aborted) begin
      check("rom_abort_data", d_to_cpu, d_before);
    end else begin
      exp_d = hit_exp ? c_data : (acked ? d : 8'hFF);
      check("rom_data", d_to_cpu, exp_d);
      repeat ($urandom_range(1, 3)) tick();
      check("rom_hold_data", d_to_cpu, exp_d);
      mem_oe = 1'b0;
      tick();
      if (CACHE_EN && acked) begin
        c_valid = 1'b1;
        c_tag   = a;
        c_data  = d;
      end
    end
  endtask

  task automatic sram_read(input logic [SAW-1:0] sa, input logic with_mem);
    int unsigned n, nw, reqs;
    sram_addr = sa;
    sram_oe   = 1'b1;
    mem_oe    = with_mem;
    mem_addr  = 25'($urandom);
    #1;
    check("srd_start_wait", wait_n, 0);
    n = 0; nw = 1; reqs = 0;
    forever begin
      tick();
      if (sdram_req) reqs++;
      if (wait_n || n >= 20) break;
      n++;
      nw++;
    end
    check("srd_wait_cycles", nw, 2);
    check("srd_no_sdram", reqs, 0);
    check("srd_data", d_to_cpu, ref_sram[sa]);
    tick();
    check("srd_hold_data", d_to_cpu, ref_sram[sa]);
    sram_oe = 1'b0;
    mem_oe  = 1'b0;
    tick();
  endtask

  task automatic sram_write(input logic [SAW-1:0] sa, input logic [7:0] dv);
    int unsigned n, nw, we_n;
    logic [SAW-1:0] wa;
    logic [7:0]     wd;
    sram_addr  = sa;
    d_from_cpu = dv;
    sram_we    = 1'b1;
    #1;
    check("swr_start_wait", wait_n, 0);
    n = 0; nw = 1; we_n = 0; wa = '0; wd = '0;
    forever begin
      tick();
      if (bram_we) begin
        we_n++;
        wa = bram_addr;
        wd = bram_wdata;
      end
      if (wait_n || n >= 20) break;
      n++;
      nw++;
    end
    tick();
    if (bram_we) we_n++;
    check("swr_we_pulses", we_n, 1);
    check("swr_addr", wa, sa);
    check("swr_wdata", wd, dv);
    check("swr_wait_cycles", nw, 2);
    sram_we = 1'b0;
    tick();
    ref_sram[sa] = dv;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_addr = '0; mem_oe = 1'b0; sram_addr = '0; sram_oe = 1'b0;
    sram_we = 1'b0; d_from_cpu = '0; flush = 1'b0; sdram_ack = 1'b0; sdram_rdata = '0;
    c_valid = 1'b0; c_tag = '0; c_data = '0;
    pool[0] = 25'h100; pool[1] = 25'h0004123; pool[2] = 25'h1FFFFFF; pool[3] = 25'h0;
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = 8'($urandom);
      ref_sram[i] = bram_mem[i];
    end
    bram_mem[15'h20] = 8'hC3;
    ref_sram[15'h20] = 8'hC3;

    repeat (3) tick();
    check("rst_wait_n", wait_n, 1);
    check("rst_sdram_req", sdram_req, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_d_to_cpu", d_to_cpu, 8'hFF);
    reset = 1'b0;
    tick();

    rom_access(25'h0004123, 3, 8'h5A, 0);
    sram_read(15'h20, 1'b1);
    sram_write(15'h0010, 8'h77);
    sram_read(15'h0010, 1'b0);

    // Never acked: abandoned after T cycles, then a late ack in IDLE.
    rom_access(25'h0000777, 0, 8'h00, 0);
    sdram_ack = 1'b1; sdram_rdata = 8'h99;
    tick();
    sdram_ack = 1'b0;
    tick();
    check("late_ack_data", d_to_cpu, 8'hFF);
    check("late_ack_req", sdram_req, 0);
    check("late_ack_wait", wait_n, 1);

    // Reset while in ROM_REQ; ack arrives two cycles later.
    mem_addr = 25'h0123456; mem_oe = 1'b1;
    tick();
    tick();
    check("rstmid_pre_req", sdram_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c_valid = 1'b0;
    check("rstmid_req", sdram_req, 0);
    check("rstmid_wait", wait_n, 1);
    check("rstmid_data", d_to_cpu, 8'hFF);
    sdram_ack = 1'b1; sdram_rdata = 8'h3C;
    tick();
    sdram_ack = 1'b0;
    tick();
    check("rstmid_ack_data", d_to_cpu, 8'hFF);
    check("rstmid_ack_req", sdram_req, 0);
    check("rstmid_ack_wait", wait_n, 1);
    mem_oe = 1'b0;
    tick();

    // Cache sequence: repeat read, flush, read again.
    rom_access(25'h100, 2, 8'hA1, 0);
    rom_access(25'h100, 2, 8'hEE, 0);
    do_flush();
    rom_access(25'h100, 4, 8'hB2, 0);

    // Strobe drops mid ROM access; data discarded.
    rom_access(25'h1ABCDE, 5, 8'h42, 2);
    rom_access(25'h1ABCDE, 2, 8'h43, 0);

    for (int i = 0; i < 80; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op < 4)       rom_access(pool[$urandom_range(0, 3)], $urandom_range(1, 6), 8'($urandom), 0);
      else if (op == 4) rom_access(pool[$urandom_range(0, 3)], $urandom_range(3, 6), 8'($urandom), $urandom_range(1, 2));
      else if (op < 7)  sram_read(SAW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if (op < 9)  sram_write(SAW'($urandom_range(0, 15)), 8'($urandom));
      else              do_flush();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
